// File: rtl/tx_lane_train_gen.sv
// Transmit-side lane training generator: filters PLL lock, sends a training pattern
// until the far end aligns, marks the end with SYNC bytes, then passes payload bytes.
module tx_lane_train_gen #(
  parameter logic [7:0]  TRAIN_PATTERN    = 8'h55,
  parameter logic [7:0]  SYNC_BYTE        = 8'hB8,
  parameter logic [7:0]  IDLE_BYTE        = 8'h00,
  parameter int unsigned MIN_TRAIN_CYCLES = 256,
  parameter int unsigned TIMEOUT_CYCLES   = 4096,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       SCLK,
  input  logic       RESETN,
  input  logic       PLL_LOCK,
  input  logic       RX_ALGN_DONE,
  input  logic       RX_ALGN_ERR,
  input  logic       TRAIN_REQ,
  input  logic [7:0] TX_DATA_IN,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] TXD,
  output logic       TX_TRAINING,
  output logic       TX_LINK_UP,
  output logic       TX_TRAIN_ERR,
  output logic [3:0] TRAIN_RETRIES
);

  localparam logic [15:0] MIN_LAST = 16'(MIN_TRAIN_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MAX_RET  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_LOCK_WAIT = 3'd0,
    ST_TRAIN     = 3'd1,
    ST_SYNC      = 3'd2,
    ST_LINK      = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic [15:0] att_cnt_q, att_cnt_d;
  logic [3:0]  retries_q, retries_d;
  logic        sync_cnt_q, sync_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        training_q, training_d;
  logic        link_up_q, link_up_d;
  logic        train_err_q, train_err_d;
  logic [3:0]  retries_inc_s;
  logic        accept_s;

  assign TX_READY      = (state_q == ST_LINK) && !TRAIN_REQ && RX_ALGN_DONE;
  assign accept_s      = TX_VALID && TX_READY;
  assign retries_inc_s = retries_q + 4'd1;

  assign TXD           = txd_q;
  assign TX_TRAINING   = training_q;
  assign TX_LINK_UP    = link_up_q;
  assign TX_TRAIN_ERR  = train_err_q;
  assign TRAIN_RETRIES = retries_q;

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    att_cnt_d  = att_cnt_q;
    retries_d  = retries_q;
    sync_cnt_d = sync_cnt_q;

    if ((state_q != ST_LOCK_WAIT) && !PLL_LOCK) begin
      state_d    = ST_LOCK_WAIT;
      lock_cnt_d = 4'd0;
      att_cnt_d  = 16'd0;
      retries_d  = 4'd0;
      sync_cnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOCK_WAIT: begin
          if (!PLL_LOCK) begin
            lock_cnt_d = 4'd0;
          end else if (lock_cnt_q == 4'd15) begin
            state_d    = ST_TRAIN;
            lock_cnt_d = 4'd0;
            att_cnt_d  = 16'd0;
          end else begin
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
        end
        ST_TRAIN: begin
          // ERR beats DONE; timeout only counts when neither fired
          if (TRAIN_REQ) begin
            att_cnt_d = 16'd0;
          end else if (RX_ALGN_ERR || (!(RX_ALGN_DONE && (att_cnt_q >= MIN_LAST)) && (att_cnt_q == TO_LAST))) begin
            att_cnt_d = 16'd0;
            retries_d = retries_inc_s;
            if (retries_inc_s == MAX_RET) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_TRAIN;
            end
          end else if (RX_ALGN_DONE && (att_cnt_q >= MIN_LAST)) begin
            state_d    = ST_SYNC;
            att_cnt_d  = 16'd0;
            sync_cnt_d = 1'b0;
          end else begin
            att_cnt_d = att_cnt_q + 16'd1;
          end
        end
        ST_SYNC: begin
          if (TRAIN_REQ || RX_ALGN_ERR) begin
            state_d    = ST_TRAIN;
            att_cnt_d  = 16'd0;
            sync_cnt_d = 1'b0;
          end else if (sync_cnt_q) begin
            state_d    = ST_LINK;
            retries_d  = 4'd0;
            sync_cnt_d = 1'b0;
          end else begin
            sync_cnt_d = 1'b1;
          end
        end
        ST_LINK: begin
          if (TRAIN_REQ || !RX_ALGN_DONE) begin
            state_d   = ST_TRAIN;
            att_cnt_d = 16'd0;
            retries_d = 4'd0;
          end else begin
            state_d = ST_LINK;
          end
        end
        ST_FAIL: begin
          if (TRAIN_REQ) begin
            state_d   = ST_TRAIN;
            att_cnt_d = 16'd0;
            retries_d = 4'd0;
          end else begin
            state_d = ST_FAIL;
          end
        end
        default: begin
          state_d    = ST_LOCK_WAIT;
          lock_cnt_d = 4'd0;
          att_cnt_d  = 16'd0;
          retries_d  = 4'd0;
          sync_cnt_d = 1'b0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state
    txd_d       = IDLE_BYTE;
    training_d  = 1'b0;
    link_up_d   = 1'b0;
    train_err_d = 1'b0;
    case (state_d)
      ST_TRAIN: begin
        txd_d      = TRAIN_PATTERN;
        training_d = 1'b1;
      end
      ST_SYNC: begin
        txd_d      = SYNC_BYTE;
        training_d = 1'b1;
      end
      ST_LINK: begin
        link_up_d = 1'b1;
        if (accept_s) begin
          txd_d = TX_DATA_IN;
        end else begin
          txd_d = IDLE_BYTE;
        end
      end
      ST_FAIL: begin
        train_err_d = 1'b1;
      end
      default: begin
        txd_d = IDLE_BYTE;
      end
    endcase
  end

  // State, counter and registered-output flops with synchronous active-low reset
  always_ff @(posedge SCLK) begin
    if (!RESETN) begin
      state_q     <= ST_LOCK_WAIT;
      lock_cnt_q  <= 4'd0;
      att_cnt_q   <= 16'd0;
      retries_q   <= 4'd0;
      sync_cnt_q  <= 1'b0;
      txd_q       <= IDLE_BYTE;
      training_q  <= 1'b0;
      link_up_q   <= 1'b0;
      train_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      att_cnt_q   <= att_cnt_d;
      retries_q   <= retries_d;
      sync_cnt_q  <= sync_cnt_d;
      txd_q       <= txd_d;
      training_q  <= training_d;
      link_up_q   <= link_up_d;
      train_err_q <= train_err_d;
    end
  end

endmodule

// File: tb/tb_tx_lane_train_gen.sv
// Directed self-checking bench for tx_lane_train_gen with default parameters.
module tb_tx_lane_train_gen;

  logic       SCLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       RX_ALGN_DONE = 1'b0;
  logic       RX_ALGN_ERR = 1'b0;
  logic       TRAIN_REQ = 1'b0;
  logic [7:0] TX_DATA_IN = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [7:0] TXD;
  logic       TX_TRAINING;
  logic       TX_LINK_UP;
  logic       TX_TRAIN_ERR;
  logic [3:0] TRAIN_RETRIES;

  int n_checks = 0;
  int n_fail   = 0;

  tx_lane_train_gen dut (
    .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK),
    .RX_ALGN_DONE(RX_ALGN_DONE), .RX_ALGN_ERR(RX_ALGN_ERR), .TRAIN_REQ(TRAIN_REQ),
    .TX_DATA_IN(TX_DATA_IN), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TXD(TXD),
    .TX_TRAINING(TX_TRAINING), .TX_LINK_UP(TX_LINK_UP), .TX_TRAIN_ERR(TX_TRAIN_ERR),
    .TRAIN_RETRIES(TRAIN_RETRIES)
  );

  always #5 SCLK = ~SCLK;

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; PLL_LOCK = 1'b0; RX_ALGN_DONE = 1'b1;
    repeat (3) tick();
    RESETN = 1'b1;
    tick();
    n_checks++;
    if ({TXD, TX_TRAINING, TX_LINK_UP, TX_TRAIN_ERR, TRAIN_RETRIES} !== {8'h00, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL reset_outputs: got txd=%h trn=%b up=%b err=%b ret=%0d, want 00/0/0/0/0",
                         TXD, TX_TRAINING, TX_LINK_UP, TX_TRAIN_ERR, TRAIN_RETRIES);
    end
    n_checks++;
    if (TX_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", TX_READY); end
  endtask

  // Lock filter with one glitch, then the full pattern / sync / link sequence
  task automatic test_lock_train_link();
    int bad;
    PLL_LOCK = 1'b1;
    repeat (10) tick();
    PLL_LOCK = 1'b0;
    tick();
    PLL_LOCK = 1'b1;
    repeat (15) tick();
    n_checks++;
    if ({TXD, TX_TRAINING} !== {8'h00, 1'b0}) begin
      n_fail++; $display("FAIL lock_filter_15: got txd=%h trn=%b want 00/0", TXD, TX_TRAINING);
    end
    tick();
    n_checks++;
    if ({TXD, TX_TRAINING} !== {8'h55, 1'b1}) begin
      n_fail++; $display("FAIL lock_filter_16: got txd=%h trn=%b want 55/1", TXD, TX_TRAINING);
    end
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (TXD !== 8'h55) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL pattern_256: got %0d non-55 cycles want 0", bad); end
    tick();
    n_checks++;
    if (TXD !== 8'hB8) begin n_fail++; $display("FAIL sync_1: got %h want b8", TXD); end
    tick();
    n_checks++;
    if (TXD !== 8'hB8) begin n_fail++; $display("FAIL sync_2: got %h want b8", TXD); end
    tick();
    n_checks++;
    if ({TXD, TX_LINK_UP, TX_TRAINING, TX_READY, TRAIN_RETRIES} !== {8'h00, 1'b1, 1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL link_entry: got txd=%h up=%b trn=%b rdy=%b ret=%0d want 00/1/0/1/0",
                         TXD, TX_LINK_UP, TX_TRAINING, TX_READY, TRAIN_RETRIES);
    end
  endtask

  task automatic test_payload();
    logic [31:0] mask;
    int          nxt;
    int          seen;
    logic        v;
    logic [7:0]  exp;
    mask = 32'b1011_0110_1110_0101_1101_0011_1011_1101;
    nxt  = 1;
    seen = 0;
    for (int i = 0; i < 48; i++) begin
      v = mask[i % 32] && (nxt <= 16);
      TX_VALID   = v;
      TX_DATA_IN = v ? 8'(nxt) : 8'hEE;
      n_checks++;
      if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL payload_ready[%0d]: got %b want 1", i, TX_READY); end
      exp = v ? 8'(nxt) : 8'h00;
      tick();
      n_checks++;
      if (TXD !== exp) begin n_fail++; $display("FAIL payload_txd[%0d]: got %h want %h", i, TXD, exp); end
      if (v) begin nxt++; seen++; end
    end
    TX_VALID = 1'b0;
    n_checks++;
    if (seen !== 16) begin n_fail++; $display("FAIL payload_count: got %0d want 16", seen); end
    // Losing alignment with a beat offered: no accept, back to training
    TX_VALID = 1'b1; TX_DATA_IN = 8'h77; RX_ALGN_DONE = 1'b0;
    #1;
    n_checks++;
    if (TX_READY !== 1'b0) begin n_fail++; $display("FAIL link_drop_ready: got %b want 0", TX_READY); end
    tick();
    TX_VALID = 1'b0;
    n_checks++;
    if ({TXD, TX_TRAINING, TX_LINK_UP, TRAIN_RETRIES} !== {8'h55, 1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL link_drop: got txd=%h trn=%b up=%b ret=%0d want 55/1/0/0",
                         TXD, TX_TRAINING, TX_LINK_UP, TRAIN_RETRIES);
    end
  endtask

  task automatic test_err_wins();
    int bad;
    repeat (300) tick();
    RX_ALGN_DONE = 1'b1; RX_ALGN_ERR = 1'b1;
    tick();
    RX_ALGN_DONE = 1'b0; RX_ALGN_ERR = 1'b0;
    n_checks++;
    if ({TXD, TRAIN_RETRIES, TX_TRAINING} !== {8'h55, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL err_wins: got txd=%h ret=%0d trn=%b want 55/1/1", TXD, TRAIN_RETRIES, TX_TRAINING);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TXD !== 8'h55) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL err_no_sync: got %0d non-55 cycles want 0", bad); end
  endtask

  task automatic test_train_req_restart();
    int n;
    repeat (100) tick();
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    RX_ALGN_DONE = 1'b1;
    n_checks++;
    if (TRAIN_RETRIES !== 4'd1) begin n_fail++; $display("FAIL req_keeps_retries: got %0d want 1", TRAIN_RETRIES); end
    n = 0;
    while ((TXD !== 8'hB8) && (n < 1000)) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 256) begin n_fail++; $display("FAIL req_restart: got sync after %0d cycles want 256", n); end
    tick();
    tick();
    n_checks++;
    if ({TX_LINK_UP, TRAIN_RETRIES} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL link_clears_retries: got up=%b ret=%0d want 1/0", TX_LINK_UP, TRAIN_RETRIES);
    end
  endtask

  task automatic test_pll_drop();
    PLL_LOCK = 1'b0; TX_VALID = 1'b1; TX_DATA_IN = 8'hAA;
    tick();
    TX_VALID = 1'b0;
    n_checks++;
    if ({TXD, TX_LINK_UP, TX_TRAINING, TX_READY} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL pll_drop: got txd=%h up=%b trn=%b rdy=%b want 00/0/0/0",
                         TXD, TX_LINK_UP, TX_TRAINING, TX_READY);
    end
  endtask

  task automatic test_timeout_fail();
    RX_ALGN_DONE = 1'b0;
    PLL_LOCK = 1'b1;
    repeat (16) tick();
    n_checks++;
    if (TXD !== 8'h55) begin n_fail++; $display("FAIL relock: got %h want 55", TXD); end
    for (int a = 1; a <= 3; a++) begin
      repeat (4095) tick();
      n_checks++;
      if (TRAIN_RETRIES !== 4'(a - 1)) begin
        n_fail++; $display("FAIL timeout_before[%0d]: got %0d want %0d", a, TRAIN_RETRIES, a - 1);
      end
      tick();
      n_checks++;
      if (TRAIN_RETRIES !== 4'(a)) begin
        n_fail++; $display("FAIL timeout_after[%0d]: got %0d want %0d", a, TRAIN_RETRIES, a);
      end
    end
    n_checks++;
    if ({TXD, TX_TRAIN_ERR, TX_TRAINING} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL fail_state: got txd=%h err=%b trn=%b want 00/1/0", TXD, TX_TRAIN_ERR, TX_TRAINING);
    end
    TRAIN_REQ = 1'b1;
    tick();
    TRAIN_REQ = 1'b0;
    n_checks++;
    if ({TXD, TX_TRAINING, TX_TRAIN_ERR, TRAIN_RETRIES} !== {8'h55, 1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL fail_exit: got txd=%h trn=%b err=%b ret=%0d want 55/1/0/0",
                         TXD, TX_TRAINING, TX_TRAIN_ERR, TRAIN_RETRIES);
    end
  endtask

  task automatic test_reset_mid_train();
    repeat (50) tick();
    RX_ALGN_ERR = 1'b1;
    tick();
    RX_ALGN_ERR = 1'b0;
    RESETN = 1'b0;
    tick();
    n_checks++;
    if ({TXD, TX_TRAINING, TX_LINK_UP, TX_TRAIN_ERR, TRAIN_RETRIES, TX_READY} !==
        {8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_train: got txd=%h trn=%b up=%b err=%b ret=%0d rdy=%b want all zero",
                         TXD, TX_TRAINING, TX_LINK_UP, TX_TRAIN_ERR, TRAIN_RETRIES, TX_READY);
    end
    RESETN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock_train_link();
    test_payload();
    test_err_wins();
    test_train_req_restart();
    test_pll_drop();
    test_timeout_fail();
    test_reset_mid_train();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_lane_train_gen.md
TX_LANE_TRAIN_GEN -- requirements
Module: tx_lane_train_gen

Interface
REQ-001 Parameter TRAIN_PATTERN, 8'h55, byte sent every cycle while training (one transition per bit).
REQ-002 Parameter SYNC_BYTE, 8'hB8, byte marking the end of training.
REQ-003 Parameter IDLE_BYTE, 8'h00, byte sent when no payload beat is available.
REQ-004 Parameter MIN_TRAIN_CYCLES, 256, minimum pattern cycles per attempt (range 1..65534).
REQ-005 Parameter TIMEOUT_CYCLES, 4096, attempt length without RX_ALGN_DONE before a retry; must exceed MIN_TRAIN_CYCLES; max 65535.
REQ-006 Parameter MAX_RETRIES, 3, failed attempts allowed before FAIL (range 1..15).
REQ-007 SCLK  in  1  sole clock; all logic on its rising edge.
REQ-008 RESETN  in  1  reset, synchronous and active-low.
REQ-009 PLL_LOCK  in  1  transmit PLL lock, synchronous to SCLK.
REQ-010 RX_ALGN_DONE  in  1  far-end bit-align done, level, pre-synchronised to SCLK.
REQ-011 RX_ALGN_ERR  in  1  far-end bit-align error, level, pre-synchronised.
REQ-012 TRAIN_REQ  in  1  single-cycle retrain request.
REQ-013 TX_DATA_IN  in  8  payload byte.
REQ-014 TX_VALID  in  1  payload byte valid.
REQ-015 TX_READY  out  1  payload accept; combinational: high iff state LINK and TRAIN_REQ low and RX_ALGN_DONE high.
REQ-016 TXD  out  8  registered parallel byte to the 8:1 serializer.
REQ-017 TX_TRAINING  out  1  registered; high in TRAIN and SYNC.
REQ-018 TX_LINK_UP  out  1  registered; high in LINK.
REQ-019 TX_TRAIN_ERR  out  1  registered; high in FAIL.
REQ-020 TRAIN_RETRIES  out  4  registered count of failed attempts in the current training sequence.

Function
REQ-021 States LOCK_WAIT, TRAIN, SYNC, LINK, FAIL; one-hot or binary encoding is free.
REQ-022 LOCK_WAIT: TXD=IDLE_BYTE; leave to TRAIN after PLL_LOCK has been high for 16 consecutive cycles; any low sample restarts the 4-bit lock-filter count.
REQ-023 PLL_LOCK low in any state other than LOCK_WAIT: next state LOCK_WAIT; lock-filter count, attempt counter and TRAIN_RETRIES cleared; this overrides every other transition.
REQ-024 TRAIN: TXD=TRAIN_PATTERN every cycle; a 16-bit attempt counter starts at 0 on entry and increments by 1 per cycle.
REQ-025 TRAIN to SYNC when attempt counter >= MIN_TRAIN_CYCLES-1 and RX_ALGN_DONE=1 and RX_ALGN_ERR=0 in the same cycle.
REQ-026 Attempt failure: RX_ALGN_ERR=1 (this wins over DONE in the same cycle), or attempt counter = TIMEOUT_CYCLES-1 without REQ-025 firing; on failure TRAIN_RETRIES increments by 1 and the attempt counter resets to 0.
REQ-027 If the incremented TRAIN_RETRIES equals MAX_RETRIES, next state FAIL; otherwise remain in TRAIN.
REQ-028 SYNC: TXD=SYNC_BYTE for exactly 2 cycles, then LINK; TRAIN_REQ or RX_ALGN_ERR during SYNC returns to TRAIN with the attempt counter at 0.
REQ-029 LINK: on entry TRAIN_RETRIES clears to 0; on an accepted beat (TX_VALID and TX_READY) TXD<=TX_DATA_IN on the next edge (latency 1 cycle), otherwise TXD<=IDLE_BYTE; there is no skid buffer and no byte is dropped or duplicated.
REQ-030 LINK to TRAIN on TRAIN_REQ=1 or RX_ALGN_DONE=0; TRAIN_RETRIES and attempt counter cleared; no beat is accepted in that cycle.
REQ-031 TRAIN_REQ during TRAIN restarts the attempt counter at 0 without incrementing TRAIN_RETRIES.
REQ-032 FAIL: TXD=IDLE_BYTE; exit only on TRAIN_REQ (to TRAIN, TRAIN_RETRIES cleared) or reset.
REQ-033 Transition priority, highest first: reset, PLL_LOCK low, TRAIN_REQ, RX_ALGN_ERR, RX_ALGN_DONE, timeout.

Reset
REQ-034 RESETN=0 sampled at an SCLK edge, in any state including mid-attempt or mid-payload: next state LOCK_WAIT; TXD=IDLE_BYTE; TX_TRAINING, TX_LINK_UP, TX_TRAIN_ERR=0; TRAIN_RETRIES=0; all counters=0.
REQ-035 Because TX_READY is a combinational decode of state, it is 0 in the first cycle after reset and stays 0 until LINK.

Verification
REQ-036 PLL_LOCK rises, RX_ALGN_DONE=1 throughout -> TXD=8'h55 starts 16 cycles after lock; SYNC_BYTE 8'hB8 sent twice after 256 pattern cycles; TX_LINK_UP=1 follows.
REQ-037 RX_ALGN_DONE held 0 -> three 4096-cycle attempts; TRAIN_RETRIES steps 1,2,3; TX_TRAIN_ERR=1 and TXD=8'h00; then TRAIN_REQ pulse -> TRAIN, TRAIN_RETRIES=0.
REQ-038 In LINK, send 0x01..0x10 with random TX_VALID gaps -> TXD shows the same sequence, 1-cycle latency, 8'h00 in gap cycles.
REQ-039 RX_ALGN_DONE and RX_ALGN_ERR both 1 at cycle 300 of TRAIN -> treated as failure, TRAIN_RETRIES=1, no SYNC.
REQ-040 PLL_LOCK drops in LINK -> LOCK_WAIT next cycle, TX_READY=0, TX_LINK_UP=0; RESETN=0 mid-TRAIN -> all outputs at reset values next cycle.
